// File: rtl/claw_pkg.sv
// Shared types and default timing for the claw-machine servo drive path.
package claw_pkg;

    // Direction codes from the claw FSM; 2'b11 is treated as stop.
    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;

    // Which side of the stop width a pulse width lies on.
    typedef enum logic [1:0] {
        SideNone,
        SidePos,
        SideNeg
    } side_e;

    typedef enum logic [1:0] {
        StStopped,
        StRamp,
        StRun,
        StDwell
    } state_e;

    // Defaults: 100 MHz clock, 50 Hz frame.
    localparam int unsigned DEF_FRAME_CLKS   = 2_000_000;
    localparam int unsigned DEF_STOP_W       = 150_000;
    localparam int unsigned DEF_POS_W        = 100_000;
    localparam int unsigned DEF_NEG_W        = 200_000;
    localparam int unsigned DEF_STEP_W       = 5_000;
    localparam int unsigned DEF_DWELL_FRAMES = 5;
    localparam int unsigned DEF_CNT_W        = 21;

endpackage

// File: rtl/servo_frame_counter.sv
// Free-running PWM frame counter with a last-clock-of-frame strobe.
module servo_frame_counter #(
    parameter int unsigned FRAME_CLKS = 2_000_000,
    parameter int unsigned CNT_W      = 21
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CLKS - 1);

    assign boundary = (cnt == LAST);

    // Count 0..FRAME_CLKS-1 and wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_ramp_pwm.sv
// Servo PWM with per-frame bounded ramping and a stop dwell on direction reversal.
module servo_ramp_pwm
    import claw_pkg::*;
#(
    parameter int unsigned FRAME_CLKS   = DEF_FRAME_CLKS,
    parameter int unsigned STOP_W       = DEF_STOP_W,
    parameter int unsigned POS_W        = DEF_POS_W,
    parameter int unsigned NEG_W        = DEF_NEG_W,
    parameter int unsigned STEP_W       = DEF_STEP_W,
    parameter int unsigned DWELL_FRAMES = DEF_DWELL_FRAMES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dir,
    input  logic       estop,
    output logic       signal,
    output logic       frame_tick,
    output logic       at_speed,
    output logic       moving
);

    localparam logic [CNT_W-1:0] STOP_WV = CNT_W'(STOP_W);
    localparam logic [CNT_W-1:0] POS_WV  = CNT_W'(POS_W);
    localparam logic [CNT_W-1:0] NEG_WV  = CNT_W'(NEG_W);
    localparam logic [CNT_W-1:0] STEP_WV = CNT_W'(STEP_W);
    localparam int unsigned DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_INIT =
        DWELL_W'((DWELL_FRAMES > 0) ? DWELL_FRAMES - 1 : 0);

    logic [CNT_W-1:0]   cnt;
    logic               boundary;
    logic [CNT_W-1:0]   cur_w_q;
    state_e             state_q;
    side_e              side_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               estop_pend_q;

    logic               estop_act;
    logic [CNT_W-1:0]   req_w;
    side_e              req_side;
    logic [CNT_W-1:0]   tgt;
    logic [CNT_W-1:0]   diff;
    logic [CNT_W-1:0]   step_w;
    state_e             step_state;

    function automatic side_e side_of(input logic [CNT_W-1:0] w);
        if (w < STOP_WV) return SidePos;
        if (w > STOP_WV) return SideNeg;
        return SideNone;
    endfunction

    servo_frame_counter #(
        .FRAME_CLKS (FRAME_CLKS),
        .CNT_W      (CNT_W)
    ) u_frame_counter (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .boundary (boundary)
    );

    // A short estop pulse mid-frame must still stop the next frame, so it is held until then.
    assign estop_act = estop | estop_pend_q;

    // Decode the requested width; estop masks dir.
    always_comb begin
        req_w = STOP_WV;
        if (!estop_act) begin
            case (dir)
                DIR_POS: req_w = POS_WV;
                DIR_NEG: req_w = NEG_WV;
                default: req_w = STOP_WV;
            endcase
        end
        req_side = side_of(req_w);
    end

    // One bounded step toward the target; a reversal aims at the stop width first.
    always_comb begin
        tgt = (req_side == side_q || side_q == SideNone) ? req_w : STOP_WV;
        if (tgt >= cur_w_q) begin
            diff   = tgt - cur_w_q;
            step_w = cur_w_q + ((diff > STEP_WV) ? STEP_WV : diff);
        end else begin
            diff   = cur_w_q - tgt;
            step_w = cur_w_q - ((diff > STEP_WV) ? STEP_WV : diff);
        end
        step_state = StRamp;
        if (step_w == req_w && req_w != STOP_WV) begin
            step_state = StRun;
        end else if (step_w == STOP_WV && req_side == SideNone) begin
            step_state = StStopped;
        end else if (step_w == STOP_WV && side_q != SideNone && req_side != side_q &&
                     DWELL_FRAMES > 0) begin
            step_state = StDwell;
        end
    end

    // Ramp FSM acting only on frame boundaries, plus registered PWM and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_w_q      <= STOP_WV;
            state_q      <= StStopped;
            side_q       <= SideNone;
            dwell_q      <= '0;
            estop_pend_q <= 1'b0;
            signal       <= 1'b0;
            frame_tick   <= 1'b0;
            at_speed     <= 1'b0;
            moving       <= 1'b0;
        end else begin
            signal       <= (cnt < cur_w_q);
            frame_tick   <= boundary;
            estop_pend_q <= boundary ? 1'b0 : (estop_pend_q | estop);
            if (boundary) begin
                if (estop_act) begin
                    cur_w_q  <= STOP_WV;
                    side_q   <= SideNone;
                    state_q  <= StStopped;
                    dwell_q  <= '0;
                    at_speed <= 1'b0;
                    moving   <= 1'b0;
                end else begin
                    unique case (state_q)
                        // STOPPED and RUN both leave (with a first step) once the request differs.
                        StStopped, StRun, StRamp: begin
                            if (state_q == StRamp || req_w != cur_w_q) begin
                                cur_w_q  <= step_w;
                                side_q   <= side_of(step_w);
                                state_q  <= step_state;
                                at_speed <= (step_state == StRun);
                                moving   <= (step_w != STOP_WV);
                                if (step_state == StDwell) begin
                                    dwell_q <= DWELL_INIT;
                                end
                            end
                        end
                        StDwell: begin
                            if (dwell_q == '0) begin
                                state_q <= (req_side == SideNone) ? StStopped : StRamp;
                            end else begin
                                dwell_q <= dwell_q - DWELL_W'(1);
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Directed bench: measures each PWM frame's high time and the status outputs.
module tb_servo_ramp_pwm;

    localparam int unsigned FRAME = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dir = 2'b00;
    logic       estop = 1'b0;
    logic       signal;
    logic       frame_tick;
    logic       at_speed;
    logic       moving;

    int n_checks = 0;
    int n_fail   = 0;

    servo_ramp_pwm #(
        .FRAME_CLKS   (FRAME),
        .STOP_W       (50),
        .POS_W        (30),
        .NEG_W        (70),
        .STEP_W       (15),
        .DWELL_FRAMES (2),
        .CNT_W        (21)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dir        (dir),
        .estop      (estop),
        .signal     (signal),
        .frame_tick (frame_tick),
        .at_speed   (at_speed),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Starts at the negedge of a frame's cnt==0 cycle; ends at the next one.
    // Optional mid-frame dir glitch (g_at >= 0) and one-cycle estop pulse (es_at >= 0).
    task automatic frame_chk(input string tag, input int ew, input int eas, input int emv,
                             input int eticks, input logic [1:0] g_dir, input int g_at,
                             input int g_len, input int es_at);
        int         w = 0;
        int         ticks = 0;
        int         first_hi = -1;
        int         as_v = 0;
        int         mv_v = 0;
        logic [1:0] saved = dir;
        for (int i = 0; i < int'(FRAME); i++) begin
            if (i == 0) begin
                as_v = int'(at_speed);
                mv_v = int'(moving);
            end
            if (signal) begin
                w++;
                if (first_hi < 0) first_hi = i;
            end
            if (frame_tick) ticks++;
            if (g_at >= 0 && i == g_at) begin
                saved = dir;
                dir = g_dir;
            end
            if (g_at >= 0 && i == g_at + g_len) dir = saved;
            if (es_at >= 0 && i == es_at) estop = 1'b1;
            if (es_at >= 0 && i == es_at + 1) estop = 1'b0;
            @(negedge clk);
        end
        check_eq({tag, ".width"}, w, ew);
        check_eq({tag, ".at_speed"}, as_v, eas);
        check_eq({tag, ".moving"}, mv_v, emv);
        check_eq({tag, ".ticks"}, ticks, eticks);
        if (eticks == 0 && ew > 0) check_eq({tag, ".first_rise"}, first_hi, 1);
    endtask

    task automatic frm(input string tag, input int ew, input int eas, input int emv);
        frame_chk(tag, ew, eas, emv, 1, 2'b00, -1, 0, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1: stop request gives 50-clock frames, status low.
        dir = 2'b00;
        do_reset();
        frame_chk("t1.f0", 50, 0, 0, 0, 2'b00, -1, 0, -1);
        frm("t1.f1", 50, 0, 0);
        frm("t1.f2", 50, 0, 0);
        frm("t1.f3", 50, 0, 0);

        // 2: pos ramp from reset.
        dir = 2'b01;
        do_reset();
        frame_chk("t2.f0", 50, 0, 0, 0, 2'b00, -1, 0, -1);
        frm("t2.f1", 35, 0, 1);
        frm("t2.f2", 30, 1, 1);
        frm("t2.f3", 30, 1, 1);

        // 3: reversal ramps through stop and dwells.
        dir = 2'b10;
        frm("t3.f0", 30, 1, 1);
        frm("t3.f1", 45, 0, 1);
        frm("t3.f2", 50, 0, 0);
        frm("t3.f3", 50, 0, 0);
        frm("t3.f4", 50, 0, 0);
        frm("t3.f5", 65, 0, 1);
        frm("t3.f6", 70, 1, 1);

        // 4: one-cycle estop pulse, then recovery without dwell.
        frame_chk("t4.f0", 70, 1, 1, 1, 2'b00, -1, 0, 40);
        frm("t4.f1", 50, 0, 0);
        frm("t4.f2", 65, 0, 1);
        frm("t4.f3", 70, 1, 1);
        dir = 2'b11;
        frm("t4.f4", 70, 1, 1);
        frm("t4.f5", 55, 0, 1);
        frm("t4.f6", 50, 0, 0);
        frm("t4.f7", 50, 0, 0);
        // Held estop masks a pos request until released.
        dir = 2'b01;
        estop = 1'b1;
        frm("t4.e0", 50, 0, 0);
        frm("t4.e1", 50, 0, 0);
        estop = 1'b0;
        frm("t4.e2", 50, 0, 0);
        frm("t4.e3", 35, 0, 1);
        frm("t4.e4", 30, 1, 1);
        dir = 2'b00;
        frm("t4.s0", 30, 1, 1);
        frm("t4.s1", 45, 0, 1);
        frm("t4.s2", 50, 0, 0);
        frm("t4.s3", 50, 0, 0);

        // 5: sub-frame dir glitches that revert are ignored.
        frame_chk("t5.g0", 50, 0, 0, 1, 2'b10, 30, 30, -1);
        frm("t5.g1", 50, 0, 0);
        dir = 2'b01;
        frame_chk("t5.g2", 50, 0, 0, 1, 2'b00, 20, 20, -1);
        frm("t5.g3", 35, 0, 1);
        frm("t5.g4", 30, 1, 1);

        // 6: reset mid-ramp abandons the ramp at once.
        do_reset();
        frame_chk("t6.f0", 50, 0, 0, 0, 2'b00, -1, 0, -1);
        repeat (40) @(negedge clk);
        check_eq("t6.pre_cur_w", int'(dut.cur_w_q), 35);
        check_eq("t6.pre_moving", int'(moving), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6.signal", int'(signal), 0);
        check_eq("t6.cnt", int'(dut.cnt), 0);
        check_eq("t6.cur_w", int'(dut.cur_w_q), 50);
        check_eq("t6.at_speed", int'(at_speed), 0);
        check_eq("t6.moving", int'(moving), 0);
        check_eq("t6.frame_tick", int'(frame_tick), 0);
        rst = 1'b0;
        frame_chk("t6.f1", 50, 0, 0, 0, 2'b00, -1, 0, -1);
        frm("t6.f2", 35, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
